// File: rtl/weight_ctrl_pkg.sv
// Shared types and defaults for the weight BRAM sequencer.
package weight_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        DRAIN,
        DONE
    } wctrl_state_e;

    localparam int unsigned RD_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/rd_valid_pipe.sv
// Tag pipeline carrying {valid, last} alongside the BRAM read latency.
module rd_valid_pipe
    import weight_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic empty
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    // Shift the tags one stage per cycle; reset discards every in-flight lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            last_sr[0]  <= in_valid & in_last;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];
    assign empty     = ~|valid_sr;

endmodule

// File: rtl/weight_bram_ctrl.sv
// Weight BRAM sequencer: streams a layer into the BRAM, then replays the
// read-address sequence for the PE array and tags the returning lanes.
module weight_bram_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH          = 8192,
    parameter int unsigned OFF_SET_SHIFT  = 2,
    parameter int unsigned DATA_WIDTH_IN  = 128,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned RD_STEP        = 4,
    parameter int unsigned RD_LATENCY     = RD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [$clog2(DEPTH):0]                        cfg_load_words,
    input  logic [$clog2(DEPTH*(2**OFF_SET_SHIFT))-1:0]   cfg_base_addr,
    input  logic [CNT_W-1:0]                              cfg_fetch_count,
    input  logic [CNT_W-1:0]                              cfg_num_passes,
    input  logic                                          in_valid,
    input  logic [DATA_WIDTH_IN-1:0]                      in_data,
    output logic                                          in_ready,
    input  logic                                          fetch_stall,
    output logic                                          bram_wr_rd_en,
    output logic [$clog2(DEPTH)-1:0]                      bram_wr_addr,
    output logic [DATA_WIDTH_IN-1:0]                      bram_data_in,
    output logic [$clog2(DEPTH*(2**OFF_SET_SHIFT))-1:0]   bram_rd_addr,
    output logic                                          out_valid,
    output logic                                          out_last,
    output logic                                          busy,
    output logic                                          done
);

    localparam int unsigned WAW = $clog2(DEPTH);
    localparam int unsigned RAW = $clog2(DEPTH*(2**OFF_SET_SHIFT));

    // A write word must split exactly into the read lanes addressed by rd_addr.
    if (DATA_WIDTH_IN != DATA_WIDTH_OUT * (2**OFF_SET_SHIFT)) begin : g_width_check
        $error("weight_bram_ctrl: DATA_WIDTH_IN must equal DATA_WIDTH_OUT << OFF_SET_SHIFT");
    end

    wctrl_state_e state, state_nxt;

    logic [WAW:0]     load_words_q;
    logic [WAW:0]     wr_cnt;
    logic [RAW-1:0]   base_q;
    logic [RAW-1:0]   rd_addr_q;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] passes_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] pass_cnt;
    logic             rd_tag_valid;
    logic             rd_tag_last;
    logic             pipe_empty;

    logic beat, issue, idx_last, pass_last, load_last;
    logic fetch_needed, cfg_fetch_needed, pipe_idle;

    assign beat             = in_valid & (state == LOAD);
    assign issue            = (state == FETCH) & ~fetch_stall;
    assign idx_last         = (idx == fetch_cnt_q - CNT_W'(1));
    assign pass_last        = (pass_cnt == passes_q - CNT_W'(1));
    assign load_last        = (wr_cnt == load_words_q - (WAW+1)'(1));
    assign fetch_needed     = (fetch_cnt_q != '0) && (passes_q != '0);
    assign cfg_fetch_needed = (cfg_fetch_count != '0) && (cfg_num_passes != '0);
    // The registered address stage holds a tag before the pipe sees it.
    assign pipe_idle        = pipe_empty & ~rd_tag_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_load_words != '0) state_nxt = LOAD;
                    else if (cfg_fetch_needed) state_nxt = FETCH;
                    else state_nxt = DRAIN;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (beat && load_last) state_nxt = fetch_needed ? FETCH : DRAIN;
            end
            FETCH: begin
                if (issue && idx_last && pass_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pipe_idle) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the job configuration on an accepted start and count load beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_words_q <= '0;
            base_q       <= '0;
            fetch_cnt_q  <= '0;
            passes_q     <= '0;
            wr_cnt       <= '0;
        end else if (state == IDLE && start) begin
            load_words_q <= cfg_load_words;
            base_q       <= cfg_base_addr;
            fetch_cnt_q  <= cfg_fetch_count;
            passes_q     <= cfg_num_passes;
            wr_cnt       <= '0;
        end else if (beat) begin
            wr_cnt <= wr_cnt + (WAW+1)'(1);
        end
    end

    // Issue reads: registered address, lane/pass counters, and the tag that
    // travels with the address into the latency pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q    <= '0;
            idx          <= '0;
            pass_cnt     <= '0;
            rd_tag_valid <= 1'b0;
            rd_tag_last  <= 1'b0;
        end else begin
            rd_tag_valid <= issue;
            rd_tag_last  <= issue & idx_last;
            if (state == IDLE && start) begin
                idx      <= '0;
                pass_cnt <= '0;
            end else if (issue) begin
                rd_addr_q <= base_q + RAW'(idx) * RAW'(RD_STEP);
                if (idx_last) begin
                    idx      <= '0;
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end else begin
                    idx <= idx + CNT_W'(1);
                end
            end
        end
    end

    rd_valid_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_tag_valid),
        .in_last  (rd_tag_last),
        .out_valid(out_valid),
        .out_last (out_last),
        .empty    (pipe_empty)
    );

    assign bram_wr_rd_en = beat;
    assign bram_wr_addr  = wr_cnt[WAW-1:0];
    assign bram_data_in  = in_data;
    assign bram_rd_addr  = rd_addr_q;

endmodule

// File: doc/weight_bram_ctrl.md
Name: weight_bram_ctrl

Overview:
- Sequencer for the general weight BRAM (128-bit write words, 32-bit registered reads, 2-cycle read latency).
- Load phase: streams a layer's weights from the DMA/loader into the BRAM via a valid/ready handshake.
- Fetch phase: generates the read-address sequence for the PE array, repeated for a configured number of passes, and tags returning data with valid/last aligned to the BRAM output.

Parameters:
- DEPTH, 8192, BRAM word count; wr_addr width WAW = clog2(DEPTH).
- OFF_SET_SHIFT, 2, BRAM read-address shift; rd_addr width RAW = clog2(DEPTH*2**OFF_SET_SHIFT).
- DATA_WIDTH_IN, 128, BRAM write word width.
- DATA_WIDTH_OUT, 32, BRAM read lane width.
- RD_STEP, 4, rd_addr increment per fetched lane.
- RD_LATENCY, 2, BRAM read latency in cycles (rd_addr to data_out).
- CNT_W, 16, width of fetch and pass counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse; latches cfg_*; ignored unless the FSM is in IDLE.
- cfg_load_words  in  WAW+1  number of 128-bit words to load.
- cfg_base_addr  in  RAW  first read address.
- cfg_fetch_count  in  CNT_W  reads per pass.
- cfg_num_passes  in  CNT_W  number of passes.
- in_valid  in  1  load stream valid.
- in_data  in  DATA_WIDTH_IN  load stream data.
- in_ready  out  1  load stream ready.
- fetch_stall  in  1  when high, no new read is issued this cycle.
- bram_wr_rd_en  out  1  BRAM write enable.
- bram_wr_addr  out  WAW  BRAM write address.
- bram_data_in  out  DATA_WIDTH_IN  BRAM write data.
- bram_rd_addr  out  RAW  BRAM read address.
- out_valid  out  1  BRAM data_out valid this cycle.
- out_last  out  1  last lane of the current pass.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: FSM to IDLE. in_ready, bram_wr_rd_en, out_valid, out_last, busy, done are all 0. Addresses and counters are 0 and valid pipeline cleared. Reset mid-operation aborts everything and does not pulse done; in-flight lanes are discarded.
- States: IDLE, LOAD, FETCH, DRAIN, DONE.
- IDLE + start: latch cfg_*. Next state is LOAD if cfg_load_words != 0; otherwise FETCH if fetch_count and num_passes are both != 0; otherwise DRAIN.
- LOAD:
  - in_ready = 1.
  - On a beat (in_valid & in_ready): bram_wr_rd_en = 1, bram_wr_addr = word counter, bram_data_in = in_data. These are combinational from the handshake; the counter is registered.
  - The counter increments per beat. After beat cfg_load_words-1, go to FETCH (or DRAIN if fetch_count or num_passes is 0).
  - in_valid low inserts a bubble with no write.
  - Writes outside LOAD never occur.
- FETCH:
  - Each cycle with fetch_stall = 0, issue one read: bram_rd_addr = base + idx*RD_STEP, registered, wrapping modulo 2^RAW. idx then increments.
  - After idx = fetch_count-1, idx returns to 0 and the pass counter increments.
  - The final issue of the final pass moves the FSM to DRAIN.
  - With fetch_stall = 1, bram_rd_addr holds and nothing is tagged.
- Valid pipeline:
  - A RD_LATENCY-deep shift register of {valid, last} per issued read.
  - out_valid/out_last appear exactly RD_LATENCY cycles after the cycle rd_addr is presented, aligned with BRAM data_out.
  - There is no backpressure on returning data; fetch_stall only gates new issues.
  - out_last is set on the idx = fetch_count-1 read of every pass.
- DRAIN: wait until the valid pipeline is empty, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- busy = (state != IDLE).
- start while busy is ignored and the latched config is unchanged.
- Counter widths: fetch_count and num_passes up to 2^CNT_W-1. No overflow handling is needed beyond modular address wrap.

Decomposition:
- Shared package weight_ctrl_pkg:
  - state enum wctrl_state_e {IDLE, LOAD, FETCH, DRAIN, DONE}.
  - constant RD_LATENCY_DEFAULT = 2.
- Sub-module rd_valid_pipe: parameterised-depth shift register of {valid, last}, with asynchronous reset clearing it.

Test Plan:
- Load 4 words, fetch 8, passes 1, base 0, no stall:
  - bram_wr_addr 0..3 on 4 consecutive beats.
  - bram_rd_addr 0, 4, ..., 28 on consecutive cycles.
  - out_valid is high 8 cycles, starting 2 cycles after the first read.
  - out_last on the 8th lane; done 1 cycle after the pipeline empties.
- Load stream with in_valid toggling 1,0,1,0: writes only on handshake cycles, wr_addr contiguous 0..N-1, no write on bubble cycles.
- Fetch 3, passes 2, base 16:
  - rd_addr 16, 20, 24, 16, 20, 24.
  - out_last on the 3rd and 6th valid lanes.
- fetch_stall high for 2 cycles mid-pass: rd_addr holds; out_valid shows a 2-cycle gap exactly 2 cycles later; no lane lost or duplicated.
- cfg_load_words = 0 with fetch_count = 0: start leads to DRAIN then DONE. done pulses within 3 cycles, with no writes and no out_valid.
- Reset asserted mid-FETCH with 2 lanes in flight: out_valid drops immediately, state is IDLE, done never pulses. A subsequent start runs cleanly.
